// File: rtl/accum_bus_rr.sv
// Multi-master accumulator bus arbiter: RR/fixed-priority write and read arbiters,
// write command FIFO, read tag FIFO. Optional RAW guard: define ACCUM_BUS_RAW_GUARD_EN.
module accum_bus_rr #(
   parameter int NUM_SLOTS  = 4,
   parameter int FIFO_DEPTH = 4,
   parameter int NUM_BANKS  = 4,
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 9,
   parameter int ARB_MODE   = 1,
   localparam int SW = $clog2(NUM_SLOTS),
   localparam int LW = NUM_BANKS * DATA_WIDTH,
   localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_SLOTS-1:0]            s_wr_valid,
   output logic [NUM_SLOTS-1:0]            s_wr_ready,
   input  logic [NUM_SLOTS-1:0]            s_wr_accum_en,
   input  logic [NUM_SLOTS*NUM_BANKS-1:0]  s_wr_mask,
   input  logic [NUM_SLOTS*ADDR_WIDTH-1:0] s_wr_addr,
   input  logic [NUM_SLOTS-1:0]            s_wd_valid,
   output logic [NUM_SLOTS-1:0]            s_wd_ready,
   input  logic [NUM_SLOTS*LW-1:0]         s_wd_data,
   input  logic [NUM_SLOTS-1:0]            s_rd_valid,
   output logic [NUM_SLOTS-1:0]            s_rd_ready,
   input  logic [NUM_SLOTS*NUM_BANKS-1:0]  s_rd_mask,
   input  logic [NUM_SLOTS*ADDR_WIDTH-1:0] s_rd_addr,
   output logic [NUM_SLOTS-1:0]            s_rvalid,
   output logic [LW-1:0]                   s_rdata,
   output logic                            m_wr_valid,
   input  logic                            m_wr_ready,
   output logic                            m_wr_accum_en,
   output logic [NUM_BANKS-1:0]            m_wr_mask,
   output logic [ADDR_WIDTH-1:0]           m_wr_addr,
   output logic [LW-1:0]                   m_wd_data,
   output logic                            m_rd_valid,
   input  logic                            m_rd_ready,
   output logic [NUM_BANKS-1:0]            m_rd_mask,
   output logic [ADDR_WIDTH-1:0]           m_rd_addr,
   input  logic                            m_rvalid,
   input  logic [LW-1:0]                   m_rdata,
   output logic [CW-1:0]                   rd_outstanding,
   output logic                            rsp_err
);

   localparam int FW = $clog2(FIFO_DEPTH);

   // Returns {found, index}; RR scans upward from ptr, fixed priority from 0.
   function automatic logic [SW:0] pick(input logic [NUM_SLOTS-1:0] req, input logic [SW-1:0] ptr);
      logic [SW:0] res;
      int j;
      res = '0;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         j = (ARB_MODE == 1) ? (int'(ptr) + k) % NUM_SLOTS : k;
         if (!res[SW] && req[j]) res = {1'b1, SW'(j)};
      end
      return res;
   endfunction

   function automatic logic [SW-1:0] nxt(input logic [SW-1:0] idx);
      return (idx == SW'(NUM_SLOTS - 1)) ? '0 : idx + 1'b1;
   endfunction

   logic [SW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [SW-1:0]         cmd_src_q  [FIFO_DEPTH];
   logic                  cmd_acc_q  [FIFO_DEPTH];
   logic [NUM_BANKS-1:0]  cmd_mask_q [FIFO_DEPTH];
   logic [ADDR_WIDTH-1:0] cmd_addr_q [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] cmd_vld_q;
   logic [FW-1:0]         cmd_wp_q, cmd_rp_q;
   logic [SW-1:0]         tag_q [FIFO_DEPTH];
   logic [FW-1:0]         tag_wp_q, tag_rp_q;
   logic [CW-1:0]         tag_cnt_q, tag_cnt_d;
   logic                  rsp_err_q, rsp_err_d;

   logic                  wr_found, rd_found, wr_acc, fire_w, cmd_full, cmd_empty;
   logic [SW-1:0]         wr_win, rd_win, head_src;
   logic [NUM_BANKS-1:0]  wr_mask_w, rd_mask_w;
   logic [ADDR_WIDTH-1:0] wr_addr_w, rd_addr_w;
   logic                  hazard, rd_ok, tag_push, tag_pop, tag_full, tag_empty;

   always_comb begin
      {wr_found, wr_win} = pick(s_wr_valid, wr_ptr_q);
      wr_mask_w = s_wr_mask[int'(wr_win)*NUM_BANKS +: NUM_BANKS];
      wr_addr_w = s_wr_addr[int'(wr_win)*ADDR_WIDTH +: ADDR_WIDTH];
      // Ring FIFO with per-entry valid bits: slot at wp occupied means full.
      cmd_full  = cmd_vld_q[cmd_wp_q];
      cmd_empty = !cmd_vld_q[cmd_rp_q];
      wr_acc    = wr_found && !cmd_full;
      s_wr_ready = '0;
      if (wr_acc) s_wr_ready[wr_win] = 1'b1;
      wr_ptr_d = wr_acc ? nxt(wr_win) : wr_ptr_q;

      head_src      = cmd_src_q[cmd_rp_q];
      m_wr_valid    = !cmd_empty && s_wd_valid[head_src];
      fire_w        = m_wr_valid && m_wr_ready;
      m_wr_accum_en = cmd_acc_q[cmd_rp_q];
      m_wr_mask     = cmd_mask_q[cmd_rp_q];
      m_wr_addr     = cmd_addr_q[cmd_rp_q];
      m_wd_data     = s_wd_data[int'(head_src)*LW +: LW];
      s_wd_ready = '0;
      if (fire_w) s_wd_ready[head_src] = 1'b1;
   end

   always_comb begin
      {rd_found, rd_win} = pick(s_rd_valid, rd_ptr_q);
      rd_mask_w = s_rd_mask[int'(rd_win)*NUM_BANKS +: NUM_BANKS];
      rd_addr_w = s_rd_addr[int'(rd_win)*ADDR_WIDTH +: ADDR_WIDTH];
      hazard = 1'b0;
`ifdef ACCUM_BUS_RAW_GUARD_EN
      // Entries popped this cycle still count: the write has not landed yet.
      for (int i = 0; i < FIFO_DEPTH; i++)
         if (cmd_vld_q[i] && cmd_addr_q[i] == rd_addr_w && |(cmd_mask_q[i] & rd_mask_w))
            hazard = 1'b1;
      if (wr_acc && wr_addr_w == rd_addr_w && |(wr_mask_w & rd_mask_w)) hazard = 1'b1;
`else
      hazard = 1'b0;
`endif
      tag_full  = (tag_cnt_q == CW'(FIFO_DEPTH));
      tag_empty = (tag_cnt_q == '0);
      rd_ok     = rd_found && m_rd_ready && !tag_full && !hazard;
      m_rd_valid = rd_ok;
      m_rd_mask  = rd_mask_w;
      m_rd_addr  = rd_addr_w;
      s_rd_ready = '0;
      if (rd_ok) s_rd_ready[rd_win] = 1'b1;
      rd_ptr_d = rd_ok ? nxt(rd_win) : rd_ptr_q;

      tag_push = rd_ok;
      tag_pop  = m_rvalid && !tag_empty;
      s_rvalid = '0;
      if (tag_pop) s_rvalid[tag_q[tag_rp_q]] = 1'b1;
      s_rdata   = m_rdata;
      tag_cnt_d = tag_cnt_q + CW'(tag_push) - CW'(tag_pop);
      rsp_err_d = m_rvalid && tag_empty;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cmd_vld_q <= '0;
         cmd_wp_q  <= '0;
         cmd_rp_q  <= '0;
         tag_wp_q  <= '0;
         tag_rp_q  <= '0;
         tag_cnt_q <= '0;
         rsp_err_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         tag_cnt_q <= tag_cnt_d;
         rsp_err_q <= rsp_err_d;
         if (wr_acc) begin
            cmd_vld_q[cmd_wp_q] <= 1'b1;
            cmd_wp_q            <= cmd_wp_q + 1'b1;
         end
         if (fire_w) begin
            cmd_vld_q[cmd_rp_q] <= 1'b0;
            cmd_rp_q            <= cmd_rp_q + 1'b1;
         end
         if (tag_push) tag_wp_q <= tag_wp_q + 1'b1;
         if (tag_pop)  tag_rp_q <= tag_rp_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         cmd_src_q[cmd_wp_q]  <= wr_win;
         cmd_acc_q[cmd_wp_q]  <= s_wr_accum_en[wr_win];
         cmd_mask_q[cmd_wp_q] <= wr_mask_w;
         cmd_addr_q[cmd_wp_q] <= wr_addr_w;
      end
      if (tag_push) tag_q[tag_wp_q] <= rd_win;
   end

   assign rd_outstanding = tag_cnt_q;
   assign rsp_err        = rsp_err_q;

endmodule

// File: tb/tb_accum_bus_rr.sv
// Self-checking bench for accum_bus_rr: directed scenarios plus randomized
// write/read traffic checked against a queue-based reference model.
module tb_accum_bus_rr;
   localparam int NS = 4, DEPTH = 4, NB = 4, DW = 16, AW = 9;
   localparam int LW = NB * DW, CW = $clog2(DEPTH + 1);
   localparam int WM = NS * NB, WA = NS * AW;

   logic clk = 1'b0, rst = 1'b0;
   logic [NS-1:0] s_wr_valid, s_wr_ready, s_wr_accum_en, s_wd_valid, s_wd_ready;
   logic [WM-1:0] s_wr_mask, s_rd_mask;
   logic [WA-1:0] s_wr_addr, s_rd_addr;
   logic [NS*LW-1:0] s_wd_data;
   logic [NS-1:0] s_rd_valid, s_rd_ready, s_rvalid;
   logic [LW-1:0] s_rdata, m_wd_data, m_rdata;
   logic m_wr_valid, m_wr_ready, m_wr_accum_en, m_rd_valid, m_rd_ready, m_rvalid, rsp_err;
   logic [NB-1:0] m_wr_mask, m_rd_mask;
   logic [AW-1:0] m_wr_addr, m_rd_addr;
   logic [CW-1:0] rd_outstanding;

   int n_cmp = 0, n_err = 0;

   accum_bus_rr #(.NUM_SLOTS(NS), .FIFO_DEPTH(DEPTH), .NUM_BANKS(NB), .DATA_WIDTH(DW),
                  .ADDR_WIDTH(AW), .ARB_MODE(1)) dut (
      .clk(clk), .rst(rst),
      .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready), .s_wr_accum_en(s_wr_accum_en),
      .s_wr_mask(s_wr_mask), .s_wr_addr(s_wr_addr),
      .s_wd_valid(s_wd_valid), .s_wd_ready(s_wd_ready), .s_wd_data(s_wd_data),
      .s_rd_valid(s_rd_valid), .s_rd_ready(s_rd_ready), .s_rd_mask(s_rd_mask),
      .s_rd_addr(s_rd_addr), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
      .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready), .m_wr_accum_en(m_wr_accum_en),
      .m_wr_mask(m_wr_mask), .m_wr_addr(m_wr_addr), .m_wd_data(m_wd_data),
      .m_rd_valid(m_rd_valid), .m_rd_ready(m_rd_ready), .m_rd_mask(m_rd_mask),
      .m_rd_addr(m_rd_addr), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
      .rd_outstanding(rd_outstanding), .rsp_err(rsp_err));

   always #5 clk = ~clk;

   typedef struct {int src; logic acc; logic [NB-1:0] mask; logic [AW-1:0] addr;} wcmd_t;

   task automatic idle_inputs();
      s_wr_valid = '0; s_wr_accum_en = '0; s_wr_mask = '0; s_wr_addr = '0;
      s_wd_valid = '0; s_wd_data = '0; s_rd_valid = '0; s_rd_mask = '0; s_rd_addr = '0;
      m_wr_ready = 1'b0; m_rd_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
   endtask

   // Leaves the bench at posedge+1 with reset released.
   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle_inputs();
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({m_wr_valid, m_rd_valid, s_rvalid, s_wd_ready, s_rd_ready, rd_outstanding, rsp_err} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got wv=%b rv=%b srv=%b wdr=%b rdr=%b out=%0d err=%b want all 0",
                  m_wr_valid, m_rd_valid, s_rvalid, s_wd_ready, s_rd_ready, rd_outstanding, rsp_err);
      end
      @(posedge clk); #1 rst = 1'b0;
      s_wr_valid = 4'b0100;
      #1;
      n_cmp++;
      if (s_wr_ready !== 4'b0100) begin
         n_err++; $display("FAIL reset_wr_ready got %b want 0100", s_wr_ready);
      end
   endtask

   task automatic test_rr_fair();
      int exp_src[5] = '{0, 1, 2, 3, 0};
      do_reset();
      s_wr_valid = '1; s_wd_valid = '1; m_wr_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if (s_wr_ready !== NS'(1 << exp_src[c])) begin
            n_err++; $display("FAIL rr_fair cyc %0d got %b want src %0d", c, s_wr_ready, exp_src[c]);
         end
         step();
      end
   endtask

   task automatic test_data_order();
      do_reset();
      m_wr_ready = 1'b1;
      s_wr_valid = 4'b0010; s_wr_addr[1*AW +: AW] = 9'd5; s_wr_mask = '1;
      @(negedge clk);
      n_cmp++;
      if (s_wr_ready !== 4'b0010) begin n_err++; $display("FAIL order_acc1 got %b want 0010", s_wr_ready); end
      step();
      s_wr_valid = 4'b0001; s_wr_addr[0 +: AW] = 9'd7; s_wd_valid = 4'b0001;
      @(negedge clk);
      n_cmp++;
      if (s_wr_ready !== 4'b0001 || m_wr_valid !== 1'b0) begin
         n_err++; $display("FAIL order_acc0 got rdy=%b wv=%b want 0001 0", s_wr_ready, m_wr_valid);
      end
      step();
      s_wr_valid = '0;
      @(negedge clk);
      n_cmp++;
      if (m_wr_valid !== 1'b0 || s_wd_ready !== '0) begin
         n_err++; $display("FAIL order_wait got wv=%b wdr=%b want 0 0000", m_wr_valid, s_wd_ready);
      end
      step();
      s_wd_valid = 4'b0011;
      @(negedge clk);
      n_cmp++;
      if (m_wr_valid !== 1'b1 || m_wr_addr !== 9'd5 || s_wd_ready !== 4'b0010) begin
         n_err++; $display("FAIL order_first got wv=%b addr=%0d wdr=%b want 1 5 0010", m_wr_valid, m_wr_addr, s_wd_ready);
      end
      step();
      @(negedge clk);
      n_cmp++;
      if (m_wr_valid !== 1'b1 || m_wr_addr !== 9'd7 || s_wd_ready !== 4'b0001) begin
         n_err++; $display("FAIL order_second got wv=%b addr=%0d wdr=%b want 1 7 0001", m_wr_valid, m_wr_addr, s_wd_ready);
      end
      step();
   endtask

   task automatic test_backpressure();
      do_reset();
      s_wr_valid = 4'b0001; s_wd_valid = 4'b0001; s_wr_mask = '1;
      for (int c = 0; c < DEPTH; c++) begin
         s_wr_addr[0 +: AW] = AW'(20 + c);
         step();
      end
      s_wr_valid = '1;
      @(negedge clk);
      n_cmp++;
      if (s_wr_ready !== '0 || m_wr_valid !== 1'b1 || m_wr_addr !== 9'd20) begin
         n_err++; $display("FAIL bp_full got rdy=%b wv=%b addr=%0d want 0000 1 20", s_wr_ready, m_wr_valid, m_wr_addr);
      end
      step();
      m_wr_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (s_wr_ready !== '0 || s_wd_ready !== 4'b0001) begin
         n_err++; $display("FAIL bp_pulse got rdy=%b wdr=%b want 0000 0001", s_wr_ready, s_wd_ready);
      end
      step();
      m_wr_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (s_wr_ready !== 4'b0010 || m_wr_addr !== 9'd21) begin
         n_err++; $display("FAIL bp_after got rdy=%b addr=%0d want 0010 21", s_wr_ready, m_wr_addr);
      end
      step();
      @(negedge clk);
      n_cmp++;
      if (s_wr_ready !== '0) begin n_err++; $display("FAIL bp_refull got %b want 0000", s_wr_ready); end
      step();
   endtask

   task automatic test_read_routing();
      logic [CW-1:0] exp_out[6] = '{0, 1, 2, 2, 1, 0};
      logic [NS-1:0] exp_rdr[6] = '{4'b0100, 4'b0001, 0, 0, 0, 0};
      logic [NS-1:0] exp_rv[6]  = '{0, 0, 0, 4'b0100, 4'b0001, 0};
      do_reset();
      m_rd_ready = 1'b1;
      s_rd_addr[2*AW +: AW] = 9'd3; s_rd_addr[0 +: AW] = 9'd4; s_rd_mask = '1;
      for (int c = 0; c < 6; c++) begin
         s_rd_valid = (c == 0) ? 4'b0100 : (c == 1) ? 4'b0001 : 4'b0000;
         m_rvalid = (c == 3 || c == 4);
         m_rdata = LW'(64'hA5A5_0000_0000_0000 + c);
         @(negedge clk);
         n_cmp++;
         if (rd_outstanding !== exp_out[c] || s_rd_ready !== exp_rdr[c] || s_rvalid !== exp_rv[c] ||
             s_rdata !== m_rdata || (c < 2 && m_rd_addr !== (c == 0 ? 9'd3 : 9'd4))) begin
            n_err++;
            $display("FAIL rd_route cyc %0d got out=%0d rdr=%b rv=%b addr=%0d want out=%0d rdr=%b rv=%b",
                     c, rd_outstanding, s_rd_ready, s_rvalid, m_rd_addr, exp_out[c], exp_rdr[c], exp_rv[c]);
         end
         step();
      end
   endtask

   task automatic test_orphan_reset();
      do_reset();
      m_rvalid = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (s_rvalid !== '0 || rsp_err !== 1'b0) begin
         n_err++; $display("FAIL orphan_now got rv=%b err=%b want 0000 0", s_rvalid, rsp_err);
      end
      step();
      m_rvalid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (rsp_err !== 1'b1) begin n_err++; $display("FAIL orphan_pulse got %b want 1", rsp_err); end
      step();
      s_rd_valid = '1; m_rd_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (rsp_err !== 1'b0) begin n_err++; $display("FAIL orphan_clear got %b want 0", rsp_err); end
      step(); step(); step();
      s_rd_valid = '0;
      @(negedge clk);
      n_cmp++;
      if (rd_outstanding !== CW'(3)) begin n_err++; $display("FAIL tags_queued got %0d want 3", rd_outstanding); end
      step();
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (rd_outstanding !== '0 || rsp_err !== 1'b0 || m_wr_valid !== 1'b0 || s_rvalid !== '0) begin
         n_err++; $display("FAIL mid_reset got out=%0d err=%b wv=%b rv=%b want 0", rd_outstanding, rsp_err, m_wr_valid, s_rvalid);
      end
      step();
      rst = 1'b0; m_rvalid = 1'b1; s_rd_valid = '1; m_rd_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (s_rvalid !== '0) begin n_err++; $display("FAIL post_reset_rv got %b want 0000", s_rvalid); end
      step();
      m_rvalid = 1'b0; m_rd_ready = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (rsp_err !== 1'b1 || s_rd_ready !== 4'b0001) begin
         n_err++; $display("FAIL post_reset_err got err=%b rdr=%b want 1 0001", rsp_err, s_rd_ready);
      end
      step();
   endtask

   task automatic test_random_write();
      wcmd_t wq[$];
      int wptr = 0, win;
      logic [NS-1:0] exp_rdy, exp_wdr;
      logic exp_mv;
      wcmd_t h;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         s_wr_valid = NS'($urandom); s_wd_valid = NS'($urandom);
         m_wr_ready = ($urandom_range(0, 3) != 0);
         s_wr_accum_en = NS'($urandom); s_wr_mask = WM'($urandom);
         s_wr_addr = WA'({$urandom, $urandom});
         for (int i = 0; i < NS * LW / 32; i++) s_wd_data[i*32 +: 32] = $urandom;
         @(negedge clk);
         win = -1;
         for (int k = 0; k < NS; k++) begin
            int j;
            j = (wptr + k) % NS;
            if (win < 0 && s_wr_valid[j]) win = j;
         end
         exp_rdy = '0;
         if (win >= 0 && wq.size() < DEPTH) exp_rdy[win] = 1'b1;
         exp_mv = (wq.size() > 0) && s_wd_valid[wq[0].src];
         exp_wdr = '0;
         if (exp_mv && m_wr_ready) exp_wdr[wq[0].src] = 1'b1;
         n_cmp++;
         if (s_wr_ready !== exp_rdy || m_wr_valid !== exp_mv || s_wd_ready !== exp_wdr) begin
            n_err++; $display("FAIL rand_wr_ctl cyc %0d got rdy=%b wv=%b wdr=%b want %b %b %b",
                              c, s_wr_ready, m_wr_valid, s_wd_ready, exp_rdy, exp_mv, exp_wdr);
         end
         if (exp_mv) begin
            h = wq[0];
            n_cmp++;
            if (m_wr_addr !== h.addr || m_wr_mask !== h.mask || m_wr_accum_en !== h.acc ||
                m_wd_data !== s_wd_data[h.src*LW +: LW]) begin
               n_err++; $display("FAIL rand_wr_fields cyc %0d got addr=%0d mask=%b acc=%b want %0d %b %b src %0d",
                                 c, m_wr_addr, m_wr_mask, m_wr_accum_en, h.addr, h.mask, h.acc, h.src);
            end
         end
         if (exp_mv && m_wr_ready) void'(wq.pop_front());
         if (exp_rdy != '0) begin
            h.src = win; h.acc = s_wr_accum_en[win];
            h.mask = s_wr_mask[win*NB +: NB]; h.addr = s_wr_addr[win*AW +: AW];
            wq.push_back(h);
            wptr = (win + 1) % NS;
         end
         step();
      end
   endtask

   task automatic test_random_read();
      int tq[$];
      int rptr = 0, win;
      logic exp_ok, err_exp;
      logic [NS-1:0] exp_rdr, exp_rv;
      do_reset();
      err_exp = 1'b0;
      for (int c = 0; c < 400; c++) begin
         s_rd_valid = NS'($urandom); m_rd_ready = ($urandom_range(0, 3) != 0);
         m_rvalid = ($urandom_range(0, 1) == 1);
         m_rdata = {$urandom, $urandom};
         s_rd_mask = WM'($urandom); s_rd_addr = WA'({$urandom, $urandom});
         @(negedge clk);
         win = -1;
         for (int k = 0; k < NS; k++) begin
            int j;
            j = (rptr + k) % NS;
            if (win < 0 && s_rd_valid[j]) win = j;
         end
         exp_ok = (win >= 0) && m_rd_ready && (tq.size() < DEPTH);
         exp_rdr = '0;
         if (exp_ok) exp_rdr[win] = 1'b1;
         exp_rv = '0;
         if (m_rvalid && tq.size() > 0) exp_rv[tq[0]] = 1'b1;
         n_cmp++;
         if (s_rd_ready !== exp_rdr || m_rd_valid !== exp_ok || s_rvalid !== exp_rv ||
             s_rdata !== m_rdata || rd_outstanding !== CW'(tq.size()) || rsp_err !== err_exp) begin
            n_err++; $display("FAIL rand_rd_ctl cyc %0d got rdr=%b rv=%b srv=%b out=%0d err=%b want %b %b %b %0d %b",
                              c, s_rd_ready, m_rd_valid, s_rvalid, rd_outstanding, rsp_err,
                              exp_rdr, exp_ok, exp_rv, tq.size(), err_exp);
         end
         if (exp_ok) begin
            n_cmp++;
            if (m_rd_addr !== s_rd_addr[win*AW +: AW] || m_rd_mask !== s_rd_mask[win*NB +: NB]) begin
               n_err++; $display("FAIL rand_rd_fields cyc %0d got addr=%0d mask=%b want slot %0d", c, m_rd_addr, m_rd_mask, win);
            end
         end
         err_exp = m_rvalid && (tq.size() == 0);
         if (m_rvalid && tq.size() > 0) void'(tq.pop_front());
         if (exp_ok) begin
            tq.push_back(win);
            rptr = (win + 1) % NS;
         end
         step();
      end
   endtask

`ifdef ACCUM_BUS_RAW_GUARD_EN
   task automatic test_raw_guard();
      do_reset();
      s_wr_valid = 4'b0010; s_wr_addr[1*AW +: AW] = 9'd9; s_wr_mask[1*NB +: NB] = 4'b0011;
      step();
      s_wr_valid = '0; m_rd_ready = 1'b1;
      s_rd_valid = 4'b0001; s_rd_addr[0 +: AW] = 9'd9; s_rd_mask[0 +: NB] = 4'b0010;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) begin m_wr_ready = 1'b1; s_wd_valid = 4'b0010; end
         @(negedge clk);
         n_cmp++;
         if (s_rd_ready !== '0 || m_rd_valid !== 1'b0) begin
            n_err++; $display("FAIL raw_stall cyc %0d got rdr=%b rv=%b want 0000 0", c, s_rd_ready, m_rd_valid);
         end
         step();
      end
      m_wr_ready = 1'b0; s_wd_valid = '0;
      @(negedge clk);
      n_cmp++;
      if (s_rd_ready !== 4'b0001) begin n_err++; $display("FAIL raw_release got %b want 0001", s_rd_ready); end
      step();
      s_rd_valid = '0; s_wr_valid = 4'b0010;
      step();
      s_wr_valid = '0; s_rd_valid = 4'b0001; s_rd_mask[0 +: NB] = 4'b1100;
      @(negedge clk);
      n_cmp++;
      if (s_rd_ready !== 4'b0001) begin n_err++; $display("FAIL raw_disjoint got %b want 0001", s_rd_ready); end
      step();
   endtask
`endif

   initial begin
      idle_inputs();
      test_reset();
      test_rr_fair();
      test_data_order();
      test_backpressure();
      test_read_routing();
      test_orphan_reset();
      test_random_write();
      test_random_read();
`ifdef ACCUM_BUS_RAW_GUARD_EN
      test_raw_guard();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
